// File: rtl/pep_pointer_chain.sv
// Pointer chain over a circular pool: P0 is the producer (write) pointer and
// P1..P_STAGE_NB are consumer stages that chase it. Each pointer carries a
// wrap bit c so that full and empty can be told apart.
// Stage 1 also has a batch timeout that fires when it sits on a partial
// batch for too long.

module pep_pointer_chain_lane #(
    parameter int PT_W    = 6,
    parameter int CNT_W   = 7,
    parameter int INC_W   = 5,
    parameter int MAX_INC = 16
) (
    input  logic             vld,
    input  logic [INC_W-1:0] nb,
    input  logic [CNT_W-1:0] elt,
    input  logic [PT_W:0]    p,
    output logic             rdy,
    output logic             acc,
    output logic             err,
    output logic [PT_W:0]    p_nxt
);
    localparam logic [INC_W-1:0] MAX_V = INC_W'(MAX_INC);

    logic nb_ok;

    // Legal amount that fits in the slots currently available to this pointer.
    // Adding in PT_W+1 bits wraps pt modulo TOTAL_NB and toggles c for free.
    always_comb begin
        nb_ok = (nb != '0) && (nb <= MAX_V);
        rdy   = nb_ok && (CNT_W'(nb) <= elt);
        acc   = vld && rdy;
        err   = vld && !nb_ok;
        p_nxt = acc ? (p + (PT_W+1)'(nb)) : p;
    end
endmodule

module pep_pointer_chain #(
    parameter int TOTAL_NB  = 64,
    parameter int STAGE_NB  = 3,
    parameter int MAX_INC   = 16,
    parameter int TIMEOUT_W = 32,
    localparam int PT_W     = $clog2(TOTAL_NB),
    localparam int CNT_W    = $clog2(TOTAL_NB + 1),
    localparam int INC_W    = $clog2(MAX_INC + 1)
) (
    input  logic                             clk,
    input  logic                             s_rst,
    input  logic [STAGE_NB:0]                inc_vld,
    input  logic [STAGE_NB:0][INC_W-1:0]     inc_nb,
    output logic [STAGE_NB:0]                inc_rdy,
    output logic [STAGE_NB:0][PT_W:0]        pt,
    output logic [STAGE_NB:0][CNT_W-1:0]     elt_nb,
    input  logic [TIMEOUT_W-1:0]             timeout_val,
    output logic                             timeout,
    output logic [STAGE_NB:0]                inc_err
);
    localparam logic [CNT_W-1:0] TOT   = CNT_W'(TOTAL_NB);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INC);

    logic [STAGE_NB:0][PT_W:0]    p_nxt;
    logic [STAGE_NB:0][CNT_W-1:0] elt_nxt;
    logic [STAGE_NB:0]            acc;
    logic [STAGE_NB:0]            err_nxt;
    logic [TIMEOUT_W-1:0]         tcnt;
    logic                         t_run;

    for (genvar i = 0; i <= STAGE_NB; i++) begin : g_lane
        pep_pointer_chain_lane #(
            .PT_W(PT_W), .CNT_W(CNT_W), .INC_W(INC_W), .MAX_INC(MAX_INC)
        ) u_lane (
            .vld   (inc_vld[i]),
            .nb    (inc_nb[i]),
            .elt   (elt_nb[i]),
            .p     (pt[i]),
            .rdy   (inc_rdy[i]),
            .acc   (acc[i]),
            .err   (err_nxt[i]),
            .p_nxt (p_nxt[i])
        );
    end

    // Counts come from the next pointers, so simultaneous advances on both
    // ends of a segment net out (+a-b) with no lost update. Subtraction in
    // PT_W+1 bits gives dist() directly, including the TOTAL_NB case.
    always_comb begin
        elt_nxt    = '0;
        elt_nxt[0] = TOT - CNT_W'(p_nxt[0] - p_nxt[STAGE_NB]);
        for (int i = 1; i <= STAGE_NB; i++)
            elt_nxt[i] = CNT_W'(p_nxt[i-1] - p_nxt[i]);
    end

    // Pointer, count and error registers; reset wins over any advance.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            pt        <= '0;
            elt_nb    <= '0;
            elt_nb[0] <= TOT;
            inc_err   <= '0;
        end else begin
            pt      <= p_nxt;
            elt_nb  <= elt_nxt;
            inc_err <= err_nxt;
        end
    end

    // Stage 1 holds a partial batch and is not consuming it.
    assign t_run = (timeout_val != '0) && (elt_nb[1] != '0) &&
                   (elt_nb[1] < MAX_C) && !acc[1];

    // Batch timeout: compare with >= so a lowered timeout_val fires at once
    // and tcnt never runs past timeout_val-1.
    always_ff @(posedge clk) begin
        if (s_rst || !t_run) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else if (tcnt >= timeout_val - TIMEOUT_W'(1)) begin
            tcnt    <= '0;
            timeout <= 1'b1;
        end else begin
            tcnt    <= tcnt + TIMEOUT_W'(1);
            timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pep_pointer_chain.sv
// Directed bench for pep_pointer_chain at default parameters.
module tb_pep_pointer_chain;
    localparam int TOTAL_NB  = 64;
    localparam int STAGE_NB  = 3;
    localparam int MAX_INC   = 16;
    localparam int TIMEOUT_W = 32;
    localparam int PT_W      = 6;
    localparam int CNT_W     = 7;
    localparam int INC_W     = 5;

    logic                         clk = 1'b0;
    logic                         s_rst;
    logic [STAGE_NB:0]            inc_vld;
    logic [STAGE_NB:0][INC_W-1:0] inc_nb;
    logic [STAGE_NB:0]            inc_rdy;
    logic [STAGE_NB:0][PT_W:0]    pt;
    logic [STAGE_NB:0][CNT_W-1:0] elt_nb;
    logic [TIMEOUT_W-1:0]         timeout_val;
    logic                         timeout;
    logic [STAGE_NB:0]            inc_err;

    int tests = 0;
    int fails = 0;

    pep_pointer_chain #(
        .TOTAL_NB(TOTAL_NB), .STAGE_NB(STAGE_NB), .MAX_INC(MAX_INC), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .s_rst(s_rst), .inc_vld(inc_vld), .inc_nb(inc_nb), .inc_rdy(inc_rdy),
        .pt(pt), .elt_nb(elt_nb), .timeout_val(timeout_val), .timeout(timeout),
        .inc_err(inc_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc_vld = '0;
        inc_nb  = '0;
        s_rst   = 1'b1;
        step();
        s_rst   = 1'b0;
    endtask

    task automatic adv(input int idx, input int nb);
        inc_vld      = '0;
        inc_vld[idx] = 1'b1;
        inc_nb[idx]  = INC_W'(nb);
        step();
        inc_vld      = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pt !== '0) begin fails++; $display("FAIL reset_pt got %h exp 0", pt); end
        tests++; if (elt_nb[0] !== 7'd64) begin fails++; $display("FAIL reset_elt0 got %0d exp 64", elt_nb[0]); end
        tests++; if (elt_nb[3:1] !== '0) begin fails++; $display("FAIL reset_elt_stages got %h exp 0", elt_nb[3:1]); end
        tests++; if (timeout !== 1'b0 || inc_err !== '0) begin fails++; $display("FAIL reset_pulses got to=%b err=%b exp 0", timeout, inc_err); end
        inc_nb = {5'd1, 5'd1, 5'd1, 5'd16};
        #1;
        tests++; if (inc_rdy !== 4'b0001) begin fails++; $display("FAIL reset_rdy got %b exp 0001", inc_rdy); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) adv(0, 16);
        tests++; if (elt_nb[0] !== 7'd0) begin fails++; $display("FAIL fill_elt0 got %0d exp 0", elt_nb[0]); end
        tests++; if (elt_nb[1] !== 7'd64) begin fails++; $display("FAIL fill_elt1 got %0d exp 64", elt_nb[1]); end
        tests++; if (pt[0] !== 7'd64) begin fails++; $display("FAIL fill_pt0 got %h exp 40", pt[0]); end
        inc_nb[0] = 5'd16;
        #1;
        tests++; if (inc_rdy[0] !== 1'b0) begin fails++; $display("FAIL fill_rdy0 got %b exp 0", inc_rdy[0]); end
        adv(0, 1);
        tests++; if (pt[0] !== 7'd64 || inc_err[0] !== 1'b0) begin fails++; $display("FAIL fill_overrun got pt=%h err=%b exp 40/0", pt[0], inc_err[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 0; s <= STAGE_NB; s++) begin
            adv(s, 16); adv(s, 16); adv(s, 16); adv(s, 12);
        end
        tests++; if (pt[3] !== 7'd60 || elt_nb[0] !== 7'd64) begin fails++; $display("FAIL wrap_setup got pt3=%0d elt0=%0d exp 60/64", pt[3], elt_nb[0]); end
        adv(0, 8);
        tests++; if (pt[0] !== 7'd68) begin fails++; $display("FAIL wrap_pt0 got %h exp 44 (c=1,pt=4)", pt[0]); end
        tests++; if (elt_nb[1] !== 7'd8) begin fails++; $display("FAIL wrap_elt1 got %0d exp 8", elt_nb[1]); end
        tests++; if (elt_nb[0] !== 7'd56) begin fails++; $display("FAIL wrap_elt0 got %0d exp 56", elt_nb[0]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        adv(0, 10);
        tests++; if (elt_nb[1] !== 7'd10) begin fails++; $display("FAIL sim_setup got %0d exp 10", elt_nb[1]); end
        inc_vld = 4'b0011;
        inc_nb  = {5'd0, 5'd0, 5'd7, 5'd5};
        step();
        inc_vld = '0;
        tests++; if (elt_nb[1] !== 7'd8) begin fails++; $display("FAIL sim_elt1 got %0d exp 8", elt_nb[1]); end
        tests++; if (elt_nb[2] !== 7'd7) begin fails++; $display("FAIL sim_elt2 got %0d exp 7", elt_nb[2]); end
        tests++; if (elt_nb[0] !== 7'd49) begin fails++; $display("FAIL sim_elt0 got %0d exp 49", elt_nb[0]); end
    endtask

    task automatic test_timeout();
        int at;
        int pulses;
        do_reset();
        timeout_val = 100;
        adv(0, 3);
        at = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (timeout === 1'b1) begin at = k; break; end
        end
        tests++; if (at != 100) begin fails++; $display("FAIL timeout_cycle got %0d exp 100", at); end
        step();
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_width got %b exp 0", timeout); end

        do_reset();
        adv(0, 3);
        pulses = 0;
        for (int k = 1; k <= 49; k++) begin step(); if (timeout === 1'b1) pulses++; end
        adv(1, 3);
        if (timeout === 1'b1) pulses++;
        for (int k = 0; k < 150; k++) begin step(); if (timeout === 1'b1) pulses++; end
        tests++; if (pulses != 0) begin fails++; $display("FAIL timeout_cancel got %0d pulses exp 0", pulses); end

        do_reset();
        timeout_val = 0;
        adv(0, 3);
        pulses = 0;
        for (int k = 0; k < 120; k++) begin step(); if (timeout === 1'b1) pulses++; end
        tests++; if (pulses != 0) begin fails++; $display("FAIL timeout_disabled got %0d pulses exp 0", pulses); end
        timeout_val = 100;
    endtask

    task automatic test_illegal();
        do_reset();
        adv(0, 16);
        adv(1, 8);
        inc_vld[2] = 1'b1; inc_nb[2] = 5'd0;
        #1;
        tests++; if (inc_rdy[2] !== 1'b0) begin fails++; $display("FAIL illegal0_rdy got %b exp 0", inc_rdy[2]); end
        step(); inc_vld = '0;
        tests++; if (inc_err !== 4'b0100) begin fails++; $display("FAIL illegal0_err got %b exp 0100", inc_err); end
        tests++; if (pt[2] !== 7'd0 || elt_nb[2] !== 7'd8) begin fails++; $display("FAIL illegal0_ptr got pt2=%0d elt2=%0d exp 0/8", pt[2], elt_nb[2]); end
        step();
        tests++; if (inc_err !== 4'b0000) begin fails++; $display("FAIL illegal_err_clear got %b exp 0000", inc_err); end
        inc_vld[2] = 1'b1; inc_nb[2] = 5'd17;
        #1;
        tests++; if (inc_rdy[2] !== 1'b0) begin fails++; $display("FAIL illegal17_rdy got %b exp 0", inc_rdy[2]); end
        step(); inc_vld = '0;
        tests++; if (inc_err[2] !== 1'b1 || pt[2] !== 7'd0) begin fails++; $display("FAIL illegal17 got err=%b pt2=%0d exp 1/0", inc_err[2], pt[2]); end
        adv(2, 9);
        tests++; if (inc_err[2] !== 1'b0 || pt[2] !== 7'd0) begin fails++; $display("FAIL notready got err=%b pt2=%0d exp 0/0", inc_err[2], pt[2]); end
        adv(2, 8);
        tests++; if (elt_nb[2] !== 7'd0 || elt_nb[3] !== 7'd8) begin fails++; $display("FAIL exact_fit got elt2=%0d elt3=%0d exp 0/8", elt_nb[2], elt_nb[3]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        adv(0, 16); adv(1, 8); adv(2, 4); adv(3, 2);
        tests++; if (pt !== {7'd2, 7'd4, 7'd8, 7'd16}) begin fails++; $display("FAIL mid_setup got %h", pt); end
        inc_vld = 4'b1111;
        inc_nb  = {5'd1, 5'd1, 5'd1, 5'd1};
        s_rst   = 1'b1;
        step();
        s_rst   = 1'b0;
        tests++; if (pt !== '0) begin fails++; $display("FAIL mid_pt got %h exp 0", pt); end
        tests++; if (elt_nb !== {7'd0, 7'd0, 7'd0, 7'd64}) begin fails++; $display("FAIL mid_elt got %h", elt_nb); end
        tests++; if (inc_err !== '0 || timeout !== 1'b0) begin fails++; $display("FAIL mid_pulses got err=%b to=%b exp 0", inc_err, timeout); end
        tests++; if (inc_rdy !== 4'b0001) begin fails++; $display("FAIL mid_rdy got %b exp 0001", inc_rdy); end
        inc_vld = '0;
    endtask

    initial begin
        s_rst       = 1'b1;
        inc_vld     = '0;
        inc_nb      = '0;
        timeout_val = 100;
        step();
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
